sram_arb: RTL and testbench

SRAM_ARB -- requirements
Module: sram_arb

---
 rtl/sram_arb_pkg.sv | 12 +
 rtl/sram_arb_rr.sv | 35 +++
 rtl/sram_arb.sv | 144 ++++++++++++++
 tb/tb_sram_arb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter slice.
//   MaxReq    : upper bound on the number of requesters the arbiter supports.
//   req_idx_t : requester index, wide enough for MaxReq requesters; used for
//               the last-granted pointer and the read-ID FIFO entries.
package sram_arb_pkg;

    localparam int MaxReq = 4;
    localparam int IdxW   = $clog2(MaxReq);

    typedef logic [IdxW-1:0] req_idx_t;

endpackage

// File: rtl/sram_arb_rr.sv
// Combinational round-robin picker.
//   eligible : requesters allowed to win this cycle.
//   last     : index of the most recently granted requester.
//   gnt      : one-hot grant; priority starts at last+1 and wraps to 0.
module sram_arb_rr
    import sram_arb_pkg::*;
#(
    parameter int NumReq = 2
) (
    input  logic [NumReq-1:0] eligible,
    input  req_idx_t          last,
    output logic [NumReq-1:0] gnt
);

    logic found;

    // Distance d is how far requester i sits after 'last' in wrap-around
    // order; scanning d upward finds the first eligible requester.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        gnt   = '0;
        found = 1'b0;
        for (int d = 0; d < NumReq; d++) begin
            for (int i = 0; i < NumReq; i++) begin
                if (!found && eligible[i] &&
                    ((i + NumReq - int'(last) - 1) % NumReq) == d) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_arb.sv
// Round-robin arbiter sharing one SRAM port among NumReq requesters.
//   clk_i, rst_ni          : clock, asynchronous active-low reset.
//   req_i/we_i/addr_i/
//   wdata_i/wmask_i        : per-requester access requests.
//   gnt_o                  : one-hot grant, same cycle as the SRAM request.
//   rvalid_o/rdata_o/
//   rerror_o               : read responses routed back in grant order.
//   ram_*_o / ram_*_i      : SRAM port (request side and response side).
//   err_o                  : sticky flag for an SRAM response with no read
//                            outstanding.
module sram_arb
    import sram_arb_pkg::*;
#(
    parameter int NumReq  = 2,
    parameter int SramAw  = 11,
    parameter int SramDw  = 32,
    parameter int RdDepth = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumReq-1:0]              req_i,
    input  logic [NumReq-1:0]              we_i,
    input  logic [NumReq-1:0][SramAw-1:0]  addr_i,
    input  logic [NumReq-1:0][SramDw-1:0]  wdata_i,
    input  logic [NumReq-1:0][SramDw-1:0]  wmask_i,
    output logic [NumReq-1:0]              gnt_o,
    output logic [NumReq-1:0]              rvalid_o,
    output logic [SramDw-1:0]              rdata_o,
    output logic [1:0]                     rerror_o,
    output logic                           ram_req_o,
    output logic                           ram_we_o,
    output logic [SramAw-1:0]              ram_addr_o,
    output logic [SramDw-1:0]              ram_wdata_o,
    output logic [SramDw-1:0]              ram_wmask_o,
    input  logic [SramDw-1:0]              ram_rdata_i,
    input  logic                           ram_rvalid_i,
    input  logic [1:0]                     ram_rerror_i,
    output logic                           err_o
);

    localparam int PtrW = (RdDepth > 1) ? $clog2(RdDepth) : 1;
    localparam int CntW = $clog2(RdDepth + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(RdDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    req_idx_t          fifo_q [RdDepth];
    ptr_t              wr_ptr_q, rd_ptr_q;
    cnt_t              count_q;
    req_idx_t          last_q;
    logic              err_q;

    logic              empty, full, push, pop;
    logic [NumReq-1:0] eligible, gnt;
    req_idx_t          gnt_idx, head;

    assign empty = (count_q == '0);
    assign full  = (count_q == cnt_t'(RdDepth));
    assign head  = fifo_q[rd_ptr_q];

    // Gating with rst_ni keeps grants and responses quiet while reset is held,
    // not just after the next clock edge.
    assign pop = rst_ni && ram_rvalid_i && !empty;

    // A read may take a full FIFO only if a slot frees in the same cycle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NumReq; i++) begin
            eligible[i] = rst_ni && req_i[i] && (we_i[i] || !full || pop);
        end
    end

    sram_arb_rr #(.NumReq(NumReq)) u_rr (
        .eligible (eligible),
        .last     (last_q),
        .gnt      (gnt)
    );

    assign gnt_o     = gnt;
    assign ram_req_o = |gnt;
    assign push      = |(gnt & ~we_i);

    // Grant is one-hot, so the selected requester simply overwrites the zeros.
    always_comb begin
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wmask_o = '0;
        gnt_idx     = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (gnt[i]) begin
                ram_we_o    = we_i[i];
                ram_addr_o  = addr_i[i];
                ram_wdata_o = wdata_i[i];
                ram_wmask_o = wmask_i[i];
                gnt_idx     = req_idx_t'(i);
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            rvalid_o[i] = pop && (head == req_idx_t'(i));
        end
    end

    assign rdata_o  = pop ? ram_rdata_i  : '0;
    assign rerror_o = pop ? ram_rerror_i : '0;
    assign err_o    = err_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= req_idx_t'(NumReq - 1);
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (|gnt) last_q <= gnt_idx;
            if (ram_rvalid_i && empty) err_q <= 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; an entry is only read after a push has
    // written it, and the count/pointers carry the reset state.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= gnt_idx;
    end

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb (NumReq=2, RdDepth=2): a vector table for the
// back-to-back read stream, then hand-written multi-cycle corner cases.
module tb_sram_arb;

    localparam int NumReq  = 2;
    localparam int SramAw  = 11;
    localparam int SramDw  = 32;
    localparam int RdDepth = 2;

    logic                          clk = 1'b0;
    logic                          rst_ni;
    logic [NumReq-1:0]             req, we;
    logic [NumReq-1:0][SramAw-1:0] addr;
    logic [NumReq-1:0][SramDw-1:0] wdata, wmask;
    logic [NumReq-1:0]             gnt, rvalid;
    logic [SramDw-1:0]             rdata;
    logic [1:0]                    rerror;
    logic                          ram_req, ram_we;
    logic [SramAw-1:0]             ram_addr;
    logic [SramDw-1:0]             ram_wdata, ram_wmask, ram_rdata;
    logic                          ram_rvalid;
    logic [1:0]                    ram_rerror;
    logic                          err;

    sram_arb #(
        .NumReq(NumReq), .SramAw(SramAw), .SramDw(SramDw), .RdDepth(RdDepth)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_i        (req),
        .we_i         (we),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .wmask_i      (wmask),
        .gnt_o        (gnt),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .rerror_o     (rerror),
        .ram_req_o    (ram_req),
        .ram_we_o     (ram_we),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_wmask_o  (ram_wmask),
        .ram_rdata_i  (ram_rdata),
        .ram_rvalid_i (ram_rvalid),
        .ram_rerror_i (ram_rerror),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at
    // the falling edge, well clear of the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w,
                         input logic rv, input logic [31:0] rd);
        req        = r;
        we         = w;
        ram_rvalid = rv;
        ram_rdata  = rd;
        #4;
    endtask

    typedef struct {
        logic [1:0]  req, we;
        logic        rv;
        logic [31:0] rd;
        logic [1:0]  re;
        logic [1:0]  exp_gnt, exp_rvalid;
        logic        exp_ram_req, exp_ram_we;
        logic [10:0] exp_addr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rerror;
    } vec_t;

    vec_t tbl [5];

    initial begin
        // Both requesters reading continuously, SRAM answering one cycle later.
        tbl[0] = '{2'b11, 2'b00, 1'b0, 32'h0,        2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 11'h010, 32'h0,        2'b00};
        tbl[1] = '{2'b11, 2'b00, 1'b1, 32'hA0A0A0A0, 2'b00, 2'b10, 2'b01, 1'b1, 1'b0, 11'h020, 32'hA0A0A0A0, 2'b00};
        tbl[2] = '{2'b11, 2'b00, 1'b1, 32'hB1B1B1B1, 2'b01, 2'b01, 2'b10, 1'b1, 1'b0, 11'h010, 32'hB1B1B1B1, 2'b01};
        tbl[3] = '{2'b11, 2'b00, 1'b1, 32'hC2C2C2C2, 2'b10, 2'b10, 2'b01, 1'b1, 1'b0, 11'h020, 32'hC2C2C2C2, 2'b10};
        tbl[4] = '{2'b00, 2'b00, 1'b1, 32'hD3D3D3D3, 2'b11, 2'b00, 2'b10, 1'b0, 1'b0, 11'h000, 32'hD3D3D3D3, 2'b11};

        rst_ni     = 1'b0;
        req        = '0;
        we         = '0;
        addr[0]    = 11'h010;
        addr[1]    = 11'h020;
        wdata[0]   = 32'h11110000;
        wdata[1]   = 32'h22220000;
        wmask      = '0;
        ram_rdata  = '0;
        ram_rvalid = 1'b0;
        ram_rerror = '0;

        // Reset state.
        #2;
        check("reset_gnt",     gnt,     0);
        check("reset_ram_req", ram_req, 0);
        check("reset_rvalid",  rvalid,  0);
        check("reset_err",     err,     0);
        tick();
        rst_ni = 1'b1;

        // Table: alternating reads, responses matched to grantors.
        for (int k = 0; k < 5; k++) begin
            ram_rerror = tbl[k].re;
            drive(tbl[k].req, tbl[k].we, tbl[k].rv, tbl[k].rd);
            check($sformatf("v%0d_gnt", k),     gnt,      tbl[k].exp_gnt);
            check($sformatf("v%0d_rvalid", k),  rvalid,   tbl[k].exp_rvalid);
            check($sformatf("v%0d_ram_req", k), ram_req,  tbl[k].exp_ram_req);
            check($sformatf("v%0d_ram_we", k),  ram_we,   tbl[k].exp_ram_we);
            check($sformatf("v%0d_addr", k),    ram_addr, tbl[k].exp_addr);
            check($sformatf("v%0d_rdata", k),   rdata,    tbl[k].exp_rdata);
            check($sformatf("v%0d_rerror", k),  rerror,   tbl[k].exp_rerror);
            tick();
        end
        ram_rerror = '0;

        // Write from req1, then read of the same word by req0.
        addr[1]  = 11'h005;
        wdata[1] = 32'hDEADBEEF;
        wmask[1] = 32'hFFFF0000;
        drive(2'b10, 2'b10, 1'b0, 32'h0);
        check("wr_gnt",     gnt,       2'b10);
        check("wr_ram_we",  ram_we,    1);
        check("wr_addr",    ram_addr,  11'h005);
        check("wr_wdata",   ram_wdata, 32'hDEADBEEF);
        check("wr_wmask",   ram_wmask, 32'hFFFF0000);
        check("wr_rvalid",  rvalid,    0);
        tick();
        addr[0]  = 11'h005;
        wdata[0] = 32'h12345678;
        drive(2'b01, 2'b00, 1'b0, 32'h0);
        check("rd_gnt",     gnt,       2'b01);
        check("rd_ram_we",  ram_we,    0);
        check("rd_addr",    ram_addr,  11'h005);
        check("rd_wdata",   ram_wdata, 32'h12345678);
        check("rd_wmask",   ram_wmask, 0);
        tick();
        drive(2'b00, 2'b00, 1'b1, 32'hDEAD0000);
        check("rd_rvalid",  rvalid,    2'b01);
        check("rd_rdata",   rdata,     32'hDEAD0000);
        tick();
        drive(2'b00, 2'b00, 1'b0, 32'h0);
        check("post_rvalid", rvalid,   0);
        check("post_rdata",  rdata,    0);
        check("idle_addr",   ram_addr, 0);
        tick();

        // Full FIFO: reads stall, a write still wins, order is preserved.
        addr[0] = 11'h010;
        addr[1] = 11'h020;
        drive(2'b11, 2'b00, 1'b0, 32'h0);
        check("full_a_gnt", gnt, 2'b10);
        tick();
        drive(2'b11, 2'b00, 1'b0, 32'h0);
        check("full_b_gnt", gnt, 2'b01);
        tick();
        drive(2'b11, 2'b01, 1'b0, 32'h0);
        check("full_c_gnt",    gnt,    2'b01);
        check("full_c_ram_we", ram_we, 1);
        tick();
        drive(2'b10, 2'b00, 1'b0, 32'h0);
        check("full_d_gnt",     gnt,     2'b00);
        check("full_d_ram_req", ram_req, 0);
        tick();
        drive(2'b10, 2'b00, 1'b1, 32'h51515151);
        check("full_e_rvalid", rvalid, 2'b10);
        check("full_e_gnt",    gnt,    2'b10);
        tick();
        drive(2'b00, 2'b00, 1'b1, 32'h52525252);
        check("full_f_rvalid", rvalid, 2'b01);
        tick();
        drive(2'b00, 2'b00, 1'b1, 32'h53535353);
        check("full_g_rvalid", rvalid, 2'b10);
        check("full_g_err",    err,    0);
        tick();

        // Spurious SRAM response with nothing outstanding.
        drive(2'b00, 2'b00, 1'b1, 32'h0BAD0BAD);
        check("spur_rvalid", rvalid, 0);
        check("spur_rdata",  rdata,  0);
        check("spur_err_0",  err,    0);
        tick();
        drive(2'b00, 2'b00, 1'b0, 32'h0);
        check("spur_err_1", err, 1);
        tick();
        tick();
        check("spur_err_held", err, 1);

        // Reset with two reads outstanding.
        drive(2'b10, 2'b00, 1'b0, 32'h0);
        check("rst_pre_a_gnt", gnt, 2'b10);
        tick();
        drive(2'b01, 2'b00, 1'b0, 32'h0);
        check("rst_pre_b_gnt", gnt, 2'b01);
        tick();
        drive(2'b11, 2'b11, 1'b0, 32'h0);
        check("rst_pre_c_gnt", gnt, 2'b10);
        ram_rvalid = 1'b1;
        rst_ni     = 1'b0;
        #1;
        check("rst_async_gnt",     gnt,     0);
        check("rst_async_ram_req", ram_req, 0);
        check("rst_async_rvalid",  rvalid,  0);
        check("rst_async_err",     err,     0);
        ram_rvalid = 1'b0;
        req        = '0;
        tick();
        tick();
        rst_ni = 1'b1;
        drive(2'b00, 2'b00, 1'b1, 32'h77777777);
        check("rst_stale_rvalid", rvalid, 0);
        tick();
        drive(2'b11, 2'b11, 1'b0, 32'h0);
        check("rst_err_set",   err, 1);
        check("rst_first_gnt", gnt, 2'b01);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
